fft8_readout_ctrl: RTL and testbench

Sequencer for the 8-point radix-2 DIT FFT core (dit_fft_8). The core exposes one bin at a time through its 3-bit sel input and 9-bit yr/yi outputs. On start, this block walks sel through all 8 bins and waits a fixed settle latency per bin. It captures each bin's yr/yi and presents it downstream as a valid/ready stream, with index and last flags. It sits between dit_fft_8 and any downstream consumer (output formatter, magnitude unit, UART dump).

---
 rtl/fft8_pkg.sv | 23 ++
 rtl/fft8_readout_ctrl.sv | 151 +++++++++++++++
 tb/tb_fft8_readout_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft8_pkg.sv
// Shared constants, FSM state type and bin-order helper for the 8-point FFT
// readout sequencer.
package fft8_pkg;

  localparam int N_PTS  = 8;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  // Maps a sequence position to the bin that is read at that position.
  function automatic logic [SEL_W-1:0] bin_order(input logic [SEL_W-1:0] b,
                                                 input logic             bitrev);
    logic [SEL_W-1:0] r;
    for (int i = 0; i < SEL_W; i++) r[i] = b[SEL_W-1-i];
    return bitrev ? r : b;
  endfunction

endpackage

// File: rtl/fft8_readout_ctrl.sv
// Walks dit_fft_8's bin select through all 8 bins, waits the core's settle
// latency per bin and presents each captured bin as a valid/ready beat.
module fft8_readout_ctrl
  import fft8_pkg::*;
#(
  parameter int unsigned SEL_LAT = 1,
  parameter bit          BITREV  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [SEL_W-1:0]  fft_sel,
  input  logic [DATA_W-1:0] fft_yr,
  input  logic [DATA_W-1:0] fft_yi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [SEL_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [SEL_W-1:0] LAT_M1   = SEL_W'(SEL_LAT - 1);
  localparam logic [SEL_W-1:0] LAST_BIN = SEL_W'(N_PTS - 1);

  state_t              r_state, w_state_nx;
  logic [SEL_W-1:0]    r_bin,   w_bin_nx;
  logic [SEL_W-1:0]    r_cnt,   w_cnt_nx;
  logic [SEL_W-1:0]    r_sel,   w_sel_nx;
  logic [SEL_W-1:0]    r_idx,   w_idx_nx;
  logic [DATA_W-1:0]   r_re,    w_re_nx;
  logic [DATA_W-1:0]   r_im,    w_im_nx;
  logic                r_valid, w_valid_nx;
  logic                r_last,  w_last_nx;
  logic                r_busy,  w_busy_nx;
  logic                r_done,  w_done_nx;
  logic                w_hs;

  assign w_hs = r_valid & out_ready;

  always_comb begin
    // NOTE: every next-value gets a hold default first so no path leaves a
    // variable unassigned, which would infer a latch.
    w_state_nx = r_state;
    w_bin_nx   = r_bin;
    w_cnt_nx   = r_cnt;
    w_sel_nx   = r_sel;
    w_idx_nx   = r_idx;
    w_re_nx    = r_re;
    w_im_nx    = r_im;
    w_valid_nx = r_valid;
    w_last_nx  = r_last;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;

    if (abort) begin
      // Cancel keeps the last captured data/index so a debugger can see it.
      w_state_nx = IDLE;
      w_valid_nx = 1'b0;
      w_busy_nx  = 1'b0;
      w_last_nx  = 1'b0;
      w_bin_nx   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            w_state_nx = SETTLE;
            w_bin_nx   = '0;
            w_sel_nx   = bin_order('0, BITREV);
            w_cnt_nx   = LAT_M1;
            w_busy_nx  = 1'b1;
          end
        end

        SETTLE: begin
          if (r_cnt == '0) begin
            w_re_nx    = fft_yr;
            w_im_nx    = fft_yi;
            w_idx_nx   = r_sel;
            w_last_nx  = (r_bin == LAST_BIN);
            w_valid_nx = 1'b1;
            w_state_nx = PRESENT;
          end else begin
            w_cnt_nx = r_cnt - 1'b1;
          end
        end

        PRESENT: begin
          if (w_hs) begin
            w_valid_nx = 1'b0;
            if (r_bin != LAST_BIN) begin
              w_bin_nx   = r_bin + 1'b1;
              w_sel_nx   = bin_order(r_bin + 1'b1, BITREV);
              w_cnt_nx   = LAT_M1;
              w_state_nx = SETTLE;
            end else begin
              w_busy_nx  = 1'b0;
              w_done_nx  = 1'b1;
              w_state_nx = IDLE;
            end
          end
        end

        default: w_state_nx = IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_idx   <= '0;
      r_re    <= '0;
      r_im    <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_bin   <= w_bin_nx;
      r_cnt   <= w_cnt_nx;
      r_sel   <= w_sel_nx;
      r_idx   <= w_idx_nx;
      r_re    <= w_re_nx;
      r_im    <= w_im_nx;
      r_valid <= w_valid_nx;
      r_last  <= w_last_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  assign fft_sel   = r_sel;
  assign out_valid = r_valid;
  assign out_re    = r_re;
  assign out_im    = r_im;
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_fft8_readout_ctrl.sv
// Bench for fft8_readout_ctrl: two instances (natural order SEL_LAT=1 and
// bit-reversed SEL_LAT=2) against a beat-level model and hand-computed pins.
module tb_fft8_readout_ctrl;

  typedef struct {
    int idx;
    int re;
    int im;
    int last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start [2];
  logic       abort [2];
  logic       ready [2];
  logic [2:0] sel_w [2];
  logic [2:0] idx_w [2];
  logic [8:0] yr    [2];
  logic [8:0] yi    [2];
  logic [8:0] re_w  [2];
  logic [8:0] im_w  [2];
  logic       valid_w [2];
  logic       last_w  [2];
  logic       busy_w  [2];
  logic       done_w  [2];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  // Behavioural FFT core: yr = 10*sel, yi = -sel, valid SEL_LAT edges after sel moves.
  function automatic logic [8:0] fft_re(input logic [2:0] s);
    return 9'(int'(s) * 10);
  endfunction
  function automatic logic [8:0] fft_im(input logic [2:0] s);
    return 9'(-int'(s));
  endfunction

  logic [2:0] sel_b_d1;
  always @(posedge clk) sel_b_d1 <= sel_w[1];

  assign yr[0] = fft_re(sel_w[0]);
  assign yi[0] = fft_im(sel_w[0]);
  assign yr[1] = fft_re(sel_b_d1);
  assign yi[1] = fft_im(sel_b_d1);

  fft8_readout_ctrl #(.SEL_LAT(1), .BITREV(1'b0)) u_dut_nat (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .fft_sel(sel_w[0]), .fft_yr(yr[0]), .fft_yi(yi[0]),
    .out_valid(valid_w[0]), .out_ready(ready[0]), .out_re(re_w[0]), .out_im(im_w[0]),
    .out_idx(idx_w[0]), .out_last(last_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  fft8_readout_ctrl #(.SEL_LAT(2), .BITREV(1'b1)) u_dut_rev (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .fft_sel(sel_w[1]), .fft_yr(yr[1]), .fft_yi(yi[1]),
    .out_valid(valid_w[1]), .out_ready(ready[1]), .out_re(re_w[1]), .out_im(im_w[1]),
    .out_idx(idx_w[1]), .out_last(last_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  // Sequence position -> bin, straight from the published read orders.
  function automatic int order_of(input int d, input int k);
    if (d == 0) return k;
    case (k)
      0: return 0;  1: return 4;  2: return 2;  3: return 6;
      4: return 1;  5: return 5;  6: return 3;  default: return 7;
    endcase
  endfunction

  // Beat-level model: beat k appears SEL_LAT edges after the previous
  // handshake (or the start accept) and carries the FFT value of order(k).
  logic       m_busy [2];
  logic       m_valid[2];
  logic       m_last [2];
  logic       m_done [2];
  logic [2:0] m_sel  [2];
  logic [2:0] m_idx  [2];
  logic [8:0] m_re   [2];
  logic [8:0] m_im   [2];
  int         m_beat [2];
  int         m_t_valid[2];
  int         m_edge;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edge <= 0;
      for (int d = 0; d < 2; d++) begin
        m_busy[d] <= 1'b0;  m_valid[d] <= 1'b0;  m_last[d] <= 1'b0;
        m_done[d] <= 1'b0;  m_sel[d]   <= '0;    m_idx[d]  <= '0;
        m_re[d]   <= '0;    m_im[d]    <= '0;    m_beat[d] <= 0;
        m_t_valid[d] <= 0;
      end
    end else begin
      m_edge <= m_edge + 1;
      for (int d = 0; d < 2; d++) begin
        m_done[d] <= 1'b0;
        if (abort[d]) begin
          m_busy[d] <= 1'b0;  m_valid[d] <= 1'b0;
          m_last[d] <= 1'b0;  m_beat[d]  <= 0;
        end else if (!m_busy[d]) begin
          if (start[d]) begin
            m_busy[d]    <= 1'b1;
            m_beat[d]    <= 0;
            m_sel[d]     <= 3'(order_of(d, 0));
            m_t_valid[d] <= m_edge + lat_of(d);
          end
        end else if (!m_valid[d]) begin
          if (m_edge == m_t_valid[d]) begin
            m_valid[d] <= 1'b1;
            m_idx[d]   <= 3'(order_of(d, m_beat[d]));
            m_re[d]    <= 9'(10 * order_of(d, m_beat[d]));
            m_im[d]    <= 9'(-order_of(d, m_beat[d]));
            m_last[d]  <= (m_beat[d] == 7);
          end
        end else if (ready[d]) begin
          m_valid[d] <= 1'b0;
          if (m_beat[d] < 7) begin
            m_beat[d]    <= m_beat[d] + 1;
            m_sel[d]     <= 3'(order_of(d, m_beat[d] + 1));
            m_t_valid[d] <= m_edge + lat_of(d);
          end else begin
            m_busy[d] <= 1'b0;
            m_done[d] <= 1'b1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s dut%0d: got %0d, want %0d", name, d, act, exp);
    end
  endtask

  // Compare process plus logs of handshakes, start accepts and done pulses.
  beat_t beats [2][$];
  int    starts[2][$];
  int    dones [2][$];
  int    ncyc = 0;
  logic  busy_prev[2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    for (int d = 0; d < 2; d++) begin
      check("out_valid", d, 32'(valid_w[d]), 32'(m_valid[d]));
      check("busy",      d, 32'(busy_w[d]),  32'(m_busy[d]));
      check("done",      d, 32'(done_w[d]),  32'(m_done[d]));
      check("fft_sel",   d, 32'(sel_w[d]),   32'(m_sel[d]));
      check("out_idx",   d, 32'(idx_w[d]),   32'(m_idx[d]));
      check("out_re",    d, 32'(re_w[d]),    32'(m_re[d]));
      check("out_im",    d, 32'(im_w[d]),    32'(m_im[d]));
      check("out_last",  d, 32'(last_w[d]),  32'(m_last[d]));
      if (valid_w[d]) check("sel_eq_idx", d, 32'(sel_w[d]), 32'(idx_w[d]));
      if (!rst) begin
        if (valid_w[d] && ready[d] && !abort[d])
          beats[d].push_back('{int'(idx_w[d]), int'(re_w[d]), int'(im_w[d]), int'(last_w[d])});
        if (busy_w[d] && !busy_prev[d]) starts[d].push_back(ncyc);
        if (done_w[d]) dones[d].push_back(ncyc);
      end
      busy_prev[d] <= busy_w[d];
    end
  end

  function automatic int frame_len(input int d, input int k);
    if (k < starts[d].size() && k < dones[d].size()) return dones[d][k] - starts[d][k];
    return -1;
  endfunction

  function automatic int beat_idx(input int d, input int k);
    return (k < beats[d].size()) ? beats[d][k].idx : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs(input int d);
    beats[d].delete();
    starts[d].delete();
    dones[d].delete();
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
  endtask

  initial begin
    int  found;
    int  n_done;
    int  rev_seq[8];
    rev_seq = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;  abort[d] = 1'b0;  ready[d] = 1'b1;
    end

    // Reset values.
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", d, 32'(valid_w[d]), 0);
      check("rst_busy",  d, 32'(busy_w[d]),  0);
      check("rst_done",  d, 32'(done_w[d]),  0);
      check("rst_sel",   d, 32'(sel_w[d]),   0);
      check("rst_re",    d, 32'(re_w[d]),    0);
    end
    rst = 1'b0;
    repeat (2) tick();

    // Natural-order frame, SEL_LAT=1.
    clear_logs(0);
    pulse_start(0);
    repeat (20) tick();
    check("nat_beats", 0, beats[0].size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < beats[0].size()) begin
        check("nat_idx",  0, beats[0][k].idx,  k);
        check("nat_re",   0, beats[0][k].re,   10 * k);
        check("nat_im",   0, beats[0][k].im,   (512 - k) % 512);
        check("nat_last", 0, beats[0][k].last, (k == 7) ? 1 : 0);
      end
    end
    check("nat_dones", 0, dones[0].size(), 1);
    check("nat_frame", 0, frame_len(0, 0), 16);

    // Bit-reversed frame, SEL_LAT=2.
    clear_logs(1);
    pulse_start(1);
    repeat (30) tick();
    check("rev_beats", 1, beats[1].size(), 8);
    for (int k = 0; k < 8; k++) begin
      check("rev_idx", 1, beat_idx(1, k), rev_seq[k]);
      if (k < beats[1].size()) check("rev_re", 1, beats[1][k].re, 10 * rev_seq[k]);
    end
    check("rev_frame", 1, frame_len(1, 0), 24);

    // Backpressure: five stalled edges on the beat for bin 2.
    clear_logs(0);
    pulse_start(0);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      tick();
      if (sel_w[0] == 3'd2 && !valid_w[0]) found = 1;
    end
    check("bp_wait", 0, found, 1);
    ready[0] = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 0, 32'(valid_w[0]), 1);
      check("bp_re",    0, 32'(re_w[0]),    20);
      check("bp_sel",   0, 32'(sel_w[0]),   2);
      tick();
    end
    ready[0] = 1'b1;
    repeat (20) tick();
    check("bp_beats", 0, beats[0].size(), 8);
    for (int k = 0; k < 8; k++) check("bp_idx", 0, beat_idx(0, k), k);
    check("bp_frame", 0, frame_len(0, 0), 21);

    // Start while busy is ignored; abort during the bin-5 beat.
    clear_logs(0);
    pulse_start(0);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      tick();
      if (sel_w[0] == 3'd4) found = 1;
    end
    check("ab_wait4", 0, found, 1);
    pulse_start(0);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (valid_w[0] && idx_w[0] == 3'd5) found = 1;
      else tick();
    end
    check("ab_wait5", 0, found, 1);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    check("ab_valid", 0, 32'(valid_w[0]), 0);
    check("ab_busy",  0, 32'(busy_w[0]),  0);
    check("ab_idx",   0, 32'(idx_w[0]),   5);
    check("ab_re",    0, 32'(re_w[0]),    50);
    check("ab_last",  0, 32'(last_w[0]),  0);
    repeat (5) tick();
    check("ab_dones",  0, dones[0].size(),  0);
    check("ab_starts", 0, starts[0].size(), 1);
    check("ab_beats",  0, beats[0].size(),  5);
    for (int k = 0; k < 5; k++) check("ab_idx_seq", 0, beat_idx(0, k), k);
    clear_logs(0);
    pulse_start(0);
    repeat (20) tick();
    check("ab_re_beats", 0, beats[0].size(), 8);
    check("ab_re_first", 0, beat_idx(0, 0), 0);
    check("ab_re_frame", 0, frame_len(0, 0), 16);

    // start and abort together in IDLE: abort wins.
    clear_logs(0);
    start[0] = 1'b1;
    abort[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    abort[0] = 1'b0;
    check("sa_busy", 0, 32'(busy_w[0]), 0);
    repeat (3) tick();
    check("sa_starts", 0, starts[0].size(), 0);

    // Back-to-back frames with start held high.
    clear_logs(0);
    start[0] = 1'b1;
    repeat (30) tick();
    start[0] = 1'b0;
    repeat (20) tick();
    check("b2b_beats", 0, beats[0].size(), 16);
    for (int k = 0; k < 16; k++) check("b2b_idx", 0, beat_idx(0, k), k % 8);
    check("b2b_dones",  0, dones[0].size(),  2);
    check("b2b_starts", 0, starts[0].size(), 2);
    check("b2b_frame0", 0, frame_len(0, 0), 16);
    check("b2b_frame1", 0, frame_len(0, 1), 16);
    if (starts[0].size() == 2 && dones[0].size() >= 1)
      check("b2b_gap", 0, starts[0][1] - dones[0][0], 1);

    // Asynchronous reset in the middle of a frame at bin 3.
    clear_logs(0);
    pulse_start(0);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      tick();
      if (valid_w[0] && idx_w[0] == 3'd3) found = 1;
    end
    check("rm_wait", 0, found, 1);
    #1 rst = 1'b1;
    #1;
    check("rm_valid", 0, 32'(valid_w[0]), 0);
    check("rm_busy",  0, 32'(busy_w[0]),  0);
    check("rm_sel",   0, 32'(sel_w[0]),   0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    n_done = dones[0].size();
    repeat (20) tick();
    check("rm_dones", 0, n_done + dones[0].size(), 0);
    check("rm_beats", 0, beats[0].size(), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
